// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Contents: FSM state encoding, fetch byte-enable constant, default
// parameter values, bus widths and the packed shared-port command payload.
package mem_arb_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned IF_ADDR_W = 24;
  localparam int unsigned STREAK_W  = 4;

  localparam int unsigned DEF_MAX_D_STREAK = 4;
  localparam int unsigned DEF_TIMEOUT      = 1023;

  localparam logic [BE_W-1:0] FETCH_BE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Command presented on the shared port while m_req is high
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared memory/flash/peripheral access port.
// master: arbiter side (drives m_req/m_we/m_be/m_addr/m_wdata, receives m_rdata/m_ack)
// slave : downstream side (dma), the mirror image.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              m_req;
  logic              m_we;
  logic [BE_W-1:0]   m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport master (output m_req, m_we, m_be, m_addr, m_wdata,
                  input  m_rdata, m_ack);
  modport slave  (input  m_req, m_we, m_be, m_addr, m_wdata,
                  output m_rdata, m_ack);

endinterface

// File: rtl/arb_timeout_ctr.sv
// Loadable up-counter with clear/enable and a terminal-count flag.
// Ports: clk, resetn (async active-low), clr (highest priority), load/load_val,
//        en (count up), term_c (combinational: count equals TERM).
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned W    = 10,
  parameter int unsigned TERM = 0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (en)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign term_c = (cnt_q == W'(TERM));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single shared memory port between instruction fetch and
// load/store. Data has priority, bounded by MAX_D_STREAK consecutive data
// grants while a fetch waits; each transaction aborts after TIMEOUT cycles
// without m_ack (0 disables).
// Ports: clk, resetn; if_* fetch requester; d_* data requester;
//        mem (mem_arbiter_if.master) shared port toward dma.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 if_req,
  input  logic [IF_ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0]    if_rdata,
  output logic                 if_ack,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [BE_W-1:0]      d_be,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_ack,
  output logic                 d_err,
  mem_arbiter_if.master        mem
);

  // A zero TIMEOUT still needs a 1-bit counter; its flag is masked off
  localparam int unsigned TO_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_TERM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TO_EN   = (TIMEOUT != 0);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                m_req_q, m_req_d;
  mem_cmd_t            cmd_q, cmd_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic                d_ack_q, d_ack_d, d_err_q, d_err_d;

  logic streak_full_c, grant_d_c, grant_i_c;
  logic to_term_c, timeout_c, to_clr_c, to_load_c, to_en_c;

  // Data wins unless the fetch has already waited out a full streak
  assign streak_full_c = (streak_q == STREAK_W'(MAX_D_STREAK));
  assign grant_d_c     = d_req & ~(if_req & streak_full_c);
  assign grant_i_c     = if_req & ~grant_d_c;

  // Counter is zeroed in IDLE, counts while granted, cleared in RESP.
  // Terminal at TIMEOUT-1 so the abort edge is the one reaching TIMEOUT.
  assign to_load_c = (state_q == IDLE);
  assign to_clr_c  = (state_q == RESP);
  assign to_en_c   = (state_q == GNT_I) || (state_q == GNT_D);
  assign timeout_c = TO_EN & to_term_c;

  arb_timeout_ctr #(
    .W    (TO_W),
    .TERM (TO_TERM)
  ) u_timeout (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (to_clr_c),
    .load     (to_load_c),
    .load_val (TO_W'(0)),
    .en       (to_en_c),
    .term_c   (to_term_c)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d_c)      state_d = GNT_D;
        else if (grant_i_c) state_d = GNT_I;
      end
      GNT_I, GNT_D: if (mem.m_ack || timeout_c) state_d = RESP;
      RESP:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    streak_d   = streak_q;
    m_req_d    = m_req_q;
    cmd_d      = cmd_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    if_err_d   = 1'b0;
    d_ack_d    = 1'b0;
    d_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          m_req_d = 1'b1;
          cmd_d   = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
          if (!if_req)            streak_d = '0;
          else if (!streak_full_c) streak_d = streak_q + STREAK_W'(1);
        end else if (grant_i_c) begin
          m_req_d  = 1'b1;
          cmd_d    = '{we: 1'b0, be: FETCH_BE, addr: ADDR_W'(if_addr), wdata: '0};
          streak_d = '0;
        end else begin
          streak_d = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (mem.m_ack) begin
          m_req_d = 1'b0;
          if (state_q == GNT_I) begin
            if_rdata_d = mem.m_rdata;
            if_ack_d   = 1'b1;
          end else begin
            d_rdata_d = cmd_q.we ? '0 : mem.m_rdata;
            d_ack_d   = 1'b1;
          end
        end else if (timeout_c) begin
          m_req_d = 1'b0;
          if (state_q == GNT_I) begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_q   <= '0;
      m_req_q    <= 1'b0;
      cmd_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      m_req_q    <= m_req_d;
      cmd_q      <= cmd_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      if_err_q   <= if_err_d;
      d_ack_q    <= d_ack_d;
      d_err_q    <= d_err_d;
    end
  end

  assign mem.m_req   = m_req_q;
  assign mem.m_we    = cmd_q.we;
  assign mem.m_be    = cmd_q.be;
  assign mem.m_addr  = cmd_q.addr;
  assign mem.m_wdata = cmd_q.wdata;
  assign if_rdata    = if_rdata_q;
  assign if_ack      = if_ack_q;
  assign if_err      = if_err_q;
  assign d_rdata     = d_rdata_q;
  assign d_ack       = d_ack_q;
  assign d_err       = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus per-cycle
// compare, a scripted memory slave, and directed scenarios with literal checks.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TB_MAX = 4;
  localparam int TB_TO  = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req;
  logic [23:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack, if_err;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack, d_err;

  mem_arbiter_if mif();

  mem_arbiter #(.MAX_D_STREAK(TB_MAX), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem(mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle counter: at the negedge of cycle c it reads c
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory slave: acks after slave_delay extra cycles of m_req, or once at late_ack_cyc
  logic        slave_en;
  int          slave_delay;
  logic [31:0] slave_rdata;
  int          late_ack_cyc;
  int          ack_cyc = 0;
  int          s_cnt = 0;
  bit          s_done = 1'b0;

  always @(negedge clk) begin
    if (cyc == late_ack_cyc) begin
      mif.m_ack   <= 1'b1;
      mif.m_rdata <= 32'h0BAD_0ACC;
    end else if (slave_en && mif.m_req && !s_done) begin
      if (s_cnt == slave_delay) begin
        mif.m_ack   <= 1'b1;
        mif.m_rdata <= slave_rdata;
        s_done      <= 1'b1;
        ack_cyc     <= cyc;
      end else begin
        s_cnt       <= s_cnt + 1;
        mif.m_ack   <= 1'b0;
        mif.m_rdata <= 32'hBAD0_0000;
      end
    end else begin
      mif.m_ack   <= 1'b0;
      mif.m_rdata <= 32'hBAD0_0000;
    end
    if (!mif.m_req) begin
      s_done <= 1'b0;
      s_cnt  <= 0;
    end
  end

  // Transaction-level model: ph 0 = free, 1 = port busy, 2 = reporting completion
  int          ph, owner, waited, streak;
  logic        e_m_req, e_we, e_if_ack, e_if_err, e_d_ack, e_d_err;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph <= 0; owner <= 0; waited <= 0; streak <= 0;
      e_m_req <= 1'b0; e_we <= 1'b0; e_be <= 4'h0; e_addr <= 32'h0; e_wdata <= 32'h0;
      e_if_ack <= 1'b0; e_if_err <= 1'b0; e_d_ack <= 1'b0; e_d_err <= 1'b0;
      e_if_rdata <= 32'h0; e_d_rdata <= 32'h0;
    end else begin
      e_if_ack <= 1'b0; e_if_err <= 1'b0; e_d_ack <= 1'b0; e_d_err <= 1'b0;
      if (ph == 0) begin
        if (d_req && !(if_req && streak == TB_MAX)) begin
          ph <= 1; owner <= 1; waited <= 0;
          e_m_req <= 1'b1; e_we <= d_we; e_be <= d_be; e_addr <= d_addr; e_wdata <= d_wdata;
          streak <= if_req ? ((streak < TB_MAX) ? streak + 1 : streak) : 0;
        end else if (if_req) begin
          ph <= 1; owner <= 0; waited <= 0;
          e_m_req <= 1'b1; e_we <= 1'b0; e_be <= 4'hF; e_addr <= {8'h00, if_addr}; e_wdata <= 32'h0;
          streak <= 0;
        end else begin
          streak <= 0;
        end
      end else if (ph == 1) begin
        if (mif.m_ack || (TB_TO != 0 && waited + 1 == TB_TO)) begin
          ph <= 2;
          e_m_req <= 1'b0;
          if (owner == 1) begin
            e_d_ack   <= 1'b1;
            e_d_err   <= !mif.m_ack;
            e_d_rdata <= (mif.m_ack && !e_we) ? mif.m_rdata : 32'h0;
          end else begin
            e_if_ack   <= 1'b1;
            e_if_err   <= !mif.m_ack;
            e_if_rdata <= mif.m_ack ? mif.m_rdata : 32'h0;
          end
        end else begin
          waited <= waited + 1;
        end
      end else begin
        ph <= 0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (resetn) begin
      chk("m_req",    32'(mif.m_req), 32'(e_m_req));
      chk("if_ack",   32'(if_ack),    32'(e_if_ack));
      chk("if_err",   32'(if_err),    32'(e_if_err));
      chk("d_ack",    32'(d_ack),     32'(e_d_ack));
      chk("d_err",    32'(d_err),     32'(e_d_err));
      chk("if_rdata", if_rdata,       e_if_rdata);
      chk("d_rdata",  d_rdata,        e_d_rdata);
      if (e_m_req) begin
        chk("m_we",    32'(mif.m_we), 32'(e_we));
        chk("m_be",    32'(mif.m_be), 32'(e_be));
        chk("m_addr",  mif.m_addr,    e_addr);
        chk("m_wdata", mif.m_wdata,   e_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit data, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (data ? d_ack : if_ack) seen = 1'b1;
    end
    chk(data ? "d_ack_arrives" : "if_ack_arrives", 32'(seen), 32'd1);
  endtask

  task automatic wait_mreq(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (mif.m_req) seen = 1'b1;
    end
    chk("m_req_arrives", 32'(seen), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"},    32'(mif.m_req),  32'd0);
    chk({tag, "_m_we"},     32'(mif.m_we),   32'd0);
    chk({tag, "_m_be"},     32'(mif.m_be),   32'd0);
    chk({tag, "_m_addr"},   mif.m_addr,      32'd0);
    chk({tag, "_m_wdata"},  mif.m_wdata,     32'd0);
    chk({tag, "_if_ack"},   32'(if_ack),     32'd0);
    chk({tag, "_if_err"},   32'(if_err),     32'd0);
    chk({tag, "_d_ack"},    32'(d_ack),      32'd0);
    chk({tag, "_d_err"},    32'(d_err),      32'd0);
    chk({tag, "_if_rdata"}, if_rdata,        32'd0);
    chk({tag, "_d_rdata"},  d_rdata,         32'd0);
  endtask

  initial begin
    bit         seen, saw_i, any;
    int         req_cyc, dack, n, hi, ack1, rise;
    logic [5:0] order;

    resetn = 1'b0; if_req = 1'b0; if_addr = 24'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    slave_en = 1'b1; slave_delay = 2; slave_rdata = 32'h0; late_ack_cyc = -1;

    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    step();
    resetn = 1'b1;
    step();

    // Fetch alone, slave acks 2 cycles after m_req rises
    slave_delay = 2; slave_rdata = 32'h0000_0513;
    if_req = 1'b1; if_addr = 24'h000010; req_cyc = cyc;
    wait_mreq(10, seen);
    chk("t1_m_addr", mif.m_addr, 32'h0000_0010);
    chk("t1_m_be",   32'(mif.m_be), 32'hF);
    chk("t1_m_we",   32'(mif.m_we), 32'd0);
    wait_ack(1'b0, 20, seen);
    chk("t1_if_rdata",   if_rdata, 32'h0000_0513);
    chk("t1_if_err",     32'(if_err), 32'd0);
    chk("t1_ack_lat",    32'(cyc - ack_cyc), 32'd1);
    chk("t1_req_to_ack", 32'(cyc - req_cyc), 32'd4);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_one_cycle", 32'(if_ack), 32'd0);
    step();

    // Simultaneous requests: data store first, then the fetch
    slave_delay = 1; slave_rdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 24'h000020;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF;
    wait_mreq(10, seen);
    chk("t2_m_we",    32'(mif.m_we), 32'd1);
    chk("t2_m_addr",  mif.m_addr,    32'h0000_0200);
    chk("t2_m_wdata", mif.m_wdata,   32'hDEAD_BEEF);
    chk("t2_m_be",    32'(mif.m_be), 32'h3);
    wait_ack(1'b1, 20, seen);
    dack = cyc;
    chk("t2_d_rdata", d_rdata, 32'h0);
    chk("t2_d_err",   32'(d_err), 32'd0);
    step(); d_req = 1'b0; d_we = 1'b0;
    wait_mreq(10, seen);
    chk("t2_fetch_gap",  32'(cyc - dack), 32'd2);
    chk("t2_fetch_addr", mif.m_addr, 32'h0000_0020);
    chk("t2_fetch_we",   32'(mif.m_we), 32'd0);
    wait_ack(1'b0, 20, seen);
    chk("t2_if_rdata", if_rdata, 32'h1234_5678);
    step(); if_req = 1'b0;
    step();

    // Starvation limit: expected completion order D,D,D,D,I,D
    slave_delay = 0; slave_rdata = 32'hA5A5_0001;
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0400; d_wdata = 32'h0;
    if_addr = 24'h000030; if_req = 1'b1; d_req = 1'b1;
    n = 0; order = 6'b0; saw_i = 1'b0;
    for (int i = 0; i < 100 && n < 6; i++) begin
      @(negedge clk);
      if (d_ack && n < 6) begin order[n] = 1'b1; n++; end
      if (if_ack && n < 6) begin order[n] = 1'b0; n++; saw_i = 1'b1; end
      step();
      if (saw_i) if_req = 1'b0;
      if (n >= 6) d_req = 1'b0;
    end
    chk("t3_grants", 32'(n), 32'd6);
    chk("t3_order",  32'(order), 32'(6'b101111));
    step();

    // Timeout: load with no m_ack, then a late ack that must be ignored
    slave_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0800;
    hi = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mif.m_req) hi++;
      if (d_ack) seen = 1'b1;
    end
    chk("t4_ack_seen",   32'(seen), 32'd1);
    chk("t4_mreq_cycles", 32'(hi), 32'd8);
    chk("t4_d_err",      32'(d_err), 32'd1);
    chk("t4_d_rdata",    d_rdata, 32'h0);
    late_ack_cyc = cyc + 3;
    step(); d_req = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if_ack || d_ack || mif.m_req) any = 1'b1;
    end
    chk("t4_late_ack_ignored", 32'(any), 32'd0);
    slave_en = 1'b1;
    step();

    // Reset while a data grant is outstanding (fetch also pending)
    slave_en = 1'b0;
    d_req = 1'b1; d_addr = 32'h0000_0900; if_req = 1'b1; if_addr = 24'h000040;
    wait_mreq(10, seen);
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero("t5");
    chk("t5_streak_rst", 32'(dut.streak_q), 32'd0);
    d_req = 1'b0;
    step();
    resetn = 1'b1;
    slave_en = 1'b1; slave_delay = 1; slave_rdata = 32'h0010_0073;
    wait_ack(1'b0, 20, seen);
    chk("t5_if_rdata", if_rdata, 32'h0010_0073);
    chk("t5_if_err",   32'(if_err), 32'd0);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("t5_streak_after", 32'(dut.streak_q), 32'd0);
    step();

    // Back-to-back data: new request right after d_ack
    slave_delay = 1; slave_rdata = 32'hCAFE_0000;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h0000_0300; d_wdata = 32'h1;
    wait_ack(1'b1, 20, seen);
    ack1 = cyc;
    step(); d_addr = 32'h0000_0304; d_wdata = 32'h2;
    rise = -1;
    for (int i = 0; i < 10 && rise < 0; i++) begin
      @(negedge clk);
      if (mif.m_req) rise = cyc;
    end
    chk("t6_gap",    32'(rise - ack1), 32'd2);
    chk("t6_m_addr", mif.m_addr, 32'h0000_0304);
    wait_ack(1'b1, 20, seen);
    step(); d_req = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mif.m_req) any = 1'b1;
    end
    chk("t6_no_regrant", 32'(any), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
